// File: rtl/clic_vector_fetch_if.sv
// Vector-fetch bus between clic_vector_fetch (initiator) and memory.
// vec_in carries the request, vec_out carries the response.
interface clic_vector_fetch_if;

    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic [31:0] mem_rdata;
        logic        mem_error;
        logic        mem_ready;
    } mem_out_type;

    mem_in_type  vec_in;
    mem_out_type vec_out;

    modport master (output vec_in, input  vec_out);
    modport slave  (input  vec_in, output vec_out);

endinterface

// File: rtl/clic_vector_fetch.sv
// clic_vector_fetch: takes the CLIC's winning interrupt and resolves its
// handler address. shv interrupts read the handler pointer from the vector
// table over the bus. Non-vectored interrupts use the mtvec base.
// Exactly one trap is presented at a time and held until trap_ack.
// Optional build macro CLIC_VECTOR_FETCH_TIMEOUT_EN adds a WAIT timeout of
// TIMEOUT_CYCLES cycles. The aborted fetch then reports trap_error with the
// mtvec base.
module clic_vector_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clic_meip,
    input  logic [11:0]                 clic_meid,
    input  logic                        clic_shv,
    input  logic                        csr_mie,
    input  logic [31:0]                 csr_mtvec,
    input  logic [31:0]                 csr_mtvt,
    clic_vector_fetch_if.master         vec,
    output logic                        trap_valid,
    output logic [11:0]                 trap_id,
    output logic [31:0]                 trap_pc,
    output logic                        trap_error,
    input  logic                        trap_ack,
    output logic                        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] id_q,    id_d;
    logic [31:0] pc_q,    pc_d;
    logic        err_q,   err_d;
    logic [31:0] addr_q,  addr_d;

    logic        take;
    logic [31:0] req_addr;
    logic [31:0] mtvec_base;

`ifdef CLIC_VECTOR_FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Ignored address bits and the handler's low bit.
    logic unused_bits;
    assign unused_bits = ^{csr_mtvec[1:0], csr_mtvt[5:0], vec.vec_out.mem_rdata[0]};

    assign take       = clic_meip && csr_mie && (clic_meid != 12'd0);
    assign mtvec_base = {csr_mtvec[31:2], 2'b00};
    // The table base is sampled live in REQ; the 32-bit add wraps naturally.
    assign req_addr   = {csr_mtvt[31:6], 6'b0} + {18'b0, id_q, 2'b00};

    // Next-state and datapath decisions for the fetch sequence.
    always_comb begin
        // NOTE: every _d gets a default first, so no path can infer a latch.
        state_d = state_q;
        id_d    = id_q;
        pc_d    = pc_q;
        err_d   = err_q;
        addr_d  = addr_q;
`ifdef CLIC_VECTOR_FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    id_d  = clic_meid;
                    // The mtvec base is the answer for non-vectored traps
                    // and the fallback when a vector fetch times out.
                    pc_d  = mtvec_base;
                    err_d = 1'b0;
                    state_d = clic_shv ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                addr_d  = req_addr;
`ifdef CLIC_VECTOR_FETCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (vec.vec_out.mem_ready) begin
                    pc_d    = {vec.vec_out.mem_rdata[31:1], 1'b0};
                    err_d   = vec.vec_out.mem_error;
                    state_d = ST_DONE;
                end
`ifdef CLIC_VECTOR_FETCH_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (trap_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and trap registers; reset is asynchronous so a mid-fetch reset
    // abandons the transaction at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= ST_IDLE;
            id_q    <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
`ifdef CLIC_VECTOR_FETCH_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
`ifdef CLIC_VECTOR_FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Read-only request: valid only in REQ; the address is held afterwards.
    assign vec.vec_in = {(state_q == ST_REQ),
                         (state_q == ST_REQ) ? req_addr : addr_q,
                         32'h0,
                         4'h0};

    assign trap_valid = (state_q == ST_DONE);
    assign trap_id    = id_q;
    assign trap_pc    = pc_q;
    assign trap_error = err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
